// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_MIPS32 successor core: default widths,
// opcode encodings, writeback latencies and the register index type.
package pipe_pkg;

    localparam int unsigned RA_W_DEF  = 5;
    localparam int unsigned LAT_W_DEF = 3;

    // Writeback latencies seen by the scoreboard at issue.
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    typedef logic [RA_W_DEF-1:0] reg_idx_t;

    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } opcode_t;

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-to-scoreboard interface: issue request, branch cancel, and the
// interlock/bypass/halt status returned to ID.
interface pipe_scoreboard_if #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned LAT_W  = 3,
    parameter int unsigned STAT_W = 16
);
    logic              iss_valid;
    logic [RA_W-1:0]   iss_rs;
    logic [RA_W-1:0]   iss_rt;
    logic              iss_use_rs;
    logic              iss_use_rt;
    logic              iss_wr;
    logic [RA_W-1:0]   iss_rd;
    logic [LAT_W-1:0]  iss_lat;
    logic              iss_hlt;
    logic              cancel;
    logic [RA_W-1:0]   cancel_rd;
    logic              stall;
    logic              iss_fire;
    logic              fwd_rs;
    logic              fwd_rt;
    logic              halted;
    logic              drained;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
               iss_wr, iss_rd, iss_lat, iss_hlt, cancel, cancel_rd,
        input  stall, iss_fire, fwd_rs, fwd_rt, halted, drained, stall_cnt
    );

    modport slave (
        input  iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
               iss_wr, iss_rd, iss_lat, iss_hlt, cancel, cancel_rd,
        output stall, iss_fire, fwd_rs, fwd_rt, halted, drained, stall_cnt
    );
endinterface

// File: rtl/pipe_sb_counter.sv
// Per-register writeback countdown. Clear beats load beats decrement.
module pipe_sb_counter #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic [LAT_W-1:0] cnt_o
);
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Next count: cancel, new issue, or one step closer to writeback.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_scoreboard.sv
// Register-hazard interlock between ID and EX. Tracks in-flight writes with
// per-register countdowns, stalls RAW/WAW hazards, sequences halt/drain and
// counts stall cycles.
// Optional: define PIPE_SCOREBOARD_FORWARD_EN to let a source whose counter
// reads 1 issue through the EX/MEM bypass instead of stalling.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned RA_W    = RA_W_DEF,
    parameter int unsigned MAX_LAT = 4,
    parameter int unsigned LAT_W   = LAT_W_DEF,
    parameter int unsigned STAT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_scoreboard_if.slave sb
);
`ifdef PIPE_SCOREBOARD_FORWARD_EN
    // A source with one cycle left is readable from the bypass.
    localparam logic [LAT_W-1:0] SRC_FREE_MAX = LAT_W'(1);
`else
    localparam logic [LAT_W-1:0] SRC_FREE_MAX = '0;
`endif

    logic [NREGS-1:0][LAT_W-1:0] cnt;
    logic [NREGS-1:1]            load_vec;
    logic [NREGS-1:1]            clr_vec;
    logic [LAT_W-1:0]            lat_c;
    logic [LAT_W-1:0]            cnt_rs;
    logic [LAT_W-1:0]            cnt_rt;
    logic [LAT_W-1:0]            cnt_rd;
    logic                        all_zero;
    logic                        hazard;
    logic                        active;
    logic                        fire;
    logic                        stall;
    logic                        halted_q;
    logic                        halted_d;
    logic [STAT_W-1:0]           stall_cnt_q;
    logic [STAT_W-1:0]           stall_cnt_d;

    // Register 0 is hardwired zero and never tracked.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        pipe_sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (clr_vec[r]),
            .load_i    (load_vec[r]),
            .load_val_i(lat_c),
            .cnt_o     (cnt[r])
        );
    end

    // Look up the counters addressed by the issuing instruction.
    always_comb begin
        cnt_rs   = '0;
        cnt_rt   = '0;
        cnt_rd   = '0;
        all_zero = 1'b1;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (sb.iss_rs == RA_W'(r)) cnt_rs = cnt[r];
            if (sb.iss_rt == RA_W'(r)) cnt_rt = cnt[r];
            if (sb.iss_rd == RA_W'(r)) cnt_rd = cnt[r];
            if (cnt[r] != '0) all_zero = 1'b0;
        end
    end

    // Hazard detection and issue decision; reset forces everything idle.
    always_comb begin
        lat_c = (sb.iss_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : sb.iss_lat;
        hazard = (sb.iss_use_rs && (cnt_rs > SRC_FREE_MAX))
              || (sb.iss_use_rt && (cnt_rt > SRC_FREE_MAX))
              || (sb.iss_wr && (lat_c != '0) && (cnt_rd > lat_c));
        active = sb.iss_valid && !halted_q && !rst;
        stall  = active && hazard;
        fire   = active && !hazard;
    end

    // Per-register load on issue and clear on cancel; the counter gives clear priority.
    always_comb begin
        load_vec = '0;
        clr_vec  = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            load_vec[r] = fire && sb.iss_wr && (sb.iss_rd == RA_W'(r)) && (lat_c != '0);
            clr_vec[r]  = sb.cancel && (sb.cancel_rd == RA_W'(r));
        end
    end

    // Sticky halt and saturating stall statistic.
    always_comb begin
        halted_d    = halted_q || (fire && sb.iss_hlt);
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.stall     = stall;
    assign sb.iss_fire  = fire;
    assign sb.halted    = halted_q;
    assign sb.drained   = halted_q && all_zero;
    assign sb.stall_cnt = stall_cnt_q;
`ifdef PIPE_SCOREBOARD_FORWARD_EN
    assign sb.fwd_rs = fire && sb.iss_use_rs && (cnt_rs == LAT_W'(1));
    assign sb.fwd_rt = fire && sb.iss_use_rt && (cnt_rt == LAT_W'(1));
`else
    assign sb.fwd_rs = 1'b0;
    assign sb.fwd_rt = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: cycle table plus cancel, halt/drain,
// asynchronous reset and stall-statistic saturation sequences.
module tb_pipe_scoreboard;
    import pipe_pkg::*;

    localparam int unsigned STAT_W = 4;
`ifdef PIPE_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       wr;
        logic [4:0] rd;
        logic [2:0] lat;
        logic       e_stall;
        logic       e_fire;
        logic       e_frs;
        logic       e_frt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];

    pipe_scoreboard_if #(.RA_W(5), .LAT_W(3), .STAT_W(STAT_W)) sb_if ();

    pipe_scoreboard #(
        .NREGS  (32),
        .RA_W   (5),
        .MAX_LAT(4),
        .LAT_W  (3),
        .STAT_W (STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic use_rs,
                                input logic [4:0] rt, input logic use_rt, input logic wr,
                                input logic [4:0] rd, input logic [2:0] lat,
                                input logic e_stall, input logic e_fire,
                                input logic e_frs, input logic e_frt);
        vec_t x;
        x.valid = valid; x.rs = rs; x.use_rs = use_rs; x.rt = rt; x.use_rt = use_rt;
        x.wr = wr; x.rd = rd; x.lat = lat;
        x.e_stall = e_stall; x.e_fire = e_fire; x.e_frs = e_frs; x.e_frt = e_frt;
        return x;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        sb_if.iss_valid  = x.valid;
        sb_if.iss_rs     = x.rs;
        sb_if.iss_use_rs = x.use_rs;
        sb_if.iss_rt     = x.rt;
        sb_if.iss_use_rt = x.use_rt;
        sb_if.iss_wr     = x.wr;
        sb_if.iss_rd     = x.rd;
        sb_if.iss_lat    = x.lat;
        sb_if.iss_hlt    = 1'b0;
        sb_if.cancel     = 1'b0;
        sb_if.cancel_rd  = '0;
    endtask

    task automatic chk_out(input string name, input vec_t x);
        chk1({name, " stall"}, sb_if.stall, x.e_stall);
        chk1({name, " fire"}, sb_if.iss_fire, x.e_fire);
        chk1({name, " fwd_rs"}, sb_if.fwd_rs, x.e_frs);
        chk1({name, " fwd_rt"}, sb_if.fwd_rt, x.e_frt);
    endtask

    // Drive one cycle, compare mid-cycle, advance past the edge.
    task automatic apply(input string name, input vec_t x);
        drive(x);
        #3;
        chk_out(name, x);
        tick();
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        #1;
        chk1("rst halted", sb_if.halted, 1'b0);
        chkn("rst stall_cnt", 32'(sb_if.stall_cnt), 0);
        #1;
        rst = 1'b0;
        tick();
    endtask

    // rd=1 lat=4 issues, then a WAW write rd=1 lat=1 waits three cycles.
    task automatic waw_round(input string name);
        apply({name, " load"}, mk(1, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            apply($sformatf("%s waw%0d", name, k), mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        end
        apply({name, " issue"}, mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0));
    endtask

    initial begin
        vec_t v;
        int   exp_sc;
        checks = 0;
        errors = 0;

        // Main cycle table: valid,rs,use_rs,rt,use_rt,wr,rd,lat | stall,fire,fwd_rs,fwd_rt
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 3'(LAT_LOAD), 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, !FWD, FWD, FWD, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 3'(LAT_ALU), 0, 1, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, !FWD, FWD, FWD, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, !FWD, FWD, 0, FWD));
        tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 7, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 3, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, !FWD, FWD, FWD, 0));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Reset state, with a valid request held to show issue is gated.
        idle();
        sb_if.iss_valid  = 1'b1;
        sb_if.iss_use_rs = 1'b1;
        sb_if.iss_rs     = 5'd1;
        rst = 1'b1;
        #3;
        chk1("reset stall", sb_if.stall, 1'b0);
        chk1("reset fire", sb_if.iss_fire, 1'b0);
        chk1("reset fwd_rs", sb_if.fwd_rs, 1'b0);
        chk1("reset fwd_rt", sb_if.fwd_rt, 1'b0);
        chk1("reset halted", sb_if.halted, 1'b0);
        chk1("reset drained", sb_if.drained, 1'b0);
        chkn("reset stall_cnt", 32'(sb_if.stall_cnt), 0);
        #10;
        rst = 1'b0;
        idle();
        tick();

        foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);
        exp_sc = FWD ? 5 : 9;
        chkn("table stall_cnt", 32'(sb_if.stall_cnt), 32'(exp_sc));

        // Cancel the only in-flight write to r5, then the dependent issues at once.
        apply("cx load5", mk(1, 0, 0, 0, 0, 1, 5, 3, 0, 1, 0, 0));
        idle();
        sb_if.cancel    = 1'b1;
        sb_if.cancel_rd = 5'd5;
        #3;
        chk1("cx cancel fire", sb_if.iss_fire, 1'b0);
        tick();
        apply("cx dep5", mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Cancel and new write to the same register in one cycle: cancel wins.
        v = mk(1, 0, 0, 0, 0, 1, 5, 3, 0, 1, 0, 0);
        drive(v);
        sb_if.cancel    = 1'b1;
        sb_if.cancel_rd = 5'd5;
        #3;
        chk_out("cx same", v);
        tick();
        apply("cx dep5b", mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // Cancel of another register leaves the new write tracked.
        v = mk(1, 0, 0, 0, 0, 1, 8, 2, 0, 1, 0, 0);
        drive(v);
        sb_if.cancel    = 1'b1;
        sb_if.cancel_rd = 5'd9;
        #3;
        chk_out("cx other", v);
        tick();
        apply("cx dep8", mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        idle();
        tick();
        tick();
        exp_sc = exp_sc + 1;

        // Halt with r2 in flight; drained follows the r2 countdown.
        apply("h load2", mk(1, 0, 0, 0, 0, 1, 2, 3, 0, 1, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb_if.iss_hlt = 1'b1;
        #3;
        chk1("h hlt fire", sb_if.iss_fire, 1'b1);
        chk1("h hlt halted", sb_if.halted, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #3;
            chk_out($sformatf("h held%0d", k), mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            chk1($sformatf("h halted%0d", k), sb_if.halted, 1'b1);
            chk1($sformatf("h drained%0d", k), sb_if.drained, 1'b0);
            tick();
        end
        #3;
        chk1("h drained", sb_if.drained, 1'b1);
        chkn("h stall_cnt frozen", 32'(sb_if.stall_cnt), 32'(exp_sc));

        // Reset while stalled with stall_cnt=7.
        pulse_reset();
        waw_round("r1");
        waw_round("r2");
        chkn("r stall_cnt6", 32'(sb_if.stall_cnt), 6);
        apply("r3 load", mk(1, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 0));
        apply("r3 waw", mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        drive(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        #1;
        chk1("r pre stall", sb_if.stall, 1'b1);
        chkn("r pre stall_cnt", 32'(sb_if.stall_cnt), 7);
        #1;
        rst = 1'b1;
        #1;
        chk1("r async stall", sb_if.stall, 1'b0);
        chk1("r async fire", sb_if.iss_fire, 1'b0);
        chk1("r async fwd_rs", sb_if.fwd_rs, 1'b0);
        chk1("r async halted", sb_if.halted, 1'b0);
        chk1("r async drained", sb_if.drained, 1'b0);
        chkn("r async stall_cnt", 32'(sb_if.stall_cnt), 0);
        #1;
        rst = 1'b0;
        #1;
        chk1("r release fire", sb_if.iss_fire, 1'b1);
        chk1("r release stall", sb_if.stall, 1'b0);
        tick();
        apply("r dep1", mk(1, 1, 1, 0, 0, 0, 0, 0, !FWD, FWD, FWD, 0));

        // Stall statistic saturates at all-ones.
        pulse_reset();
        for (int k = 1; k <= 6; k++) begin
            waw_round($sformatf("s%0d", k));
            chkn($sformatf("sat stall_cnt%0d", k), 32'(sb_if.stall_cnt),
                 32'((3 * k > 15) ? 15 : 3 * k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised register-hazard interlock for the single-clock successor of the pipe_MIPS32 core.
- Tracks in-flight destination registers with per-register countdown counters and stalls dependent issue, so programs no longer need dummy `OR R7,R7,17` spacers.
- Sits between ID and EX.
- Also provides halt/drain sequencing and a saturating stall counter for bench statistics.

Parameters:
- NREGS, 32, number of architectural registers (register 0 hardwired zero, never tracked).
- RA_W, 5, register address width; must satisfy 2**RA_W >= NREGS.
- MAX_LAT, 4, largest writeback latency accepted on iss_lat.
- LAT_W, 3, counter width; must satisfy 2**LAT_W > MAX_LAT.
- STAT_W, 16, stall statistic counter width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  ID presents an instruction.
- iss_rs  in  RA_W  source register 1.
- iss_rt  in  RA_W  source register 2.
- iss_use_rs  in  1  instruction reads rs.
- iss_use_rt  in  1  instruction reads rt.
- iss_wr  in  1  instruction writes a register.
- iss_rd  in  RA_W  destination register.
- iss_lat  in  LAT_W  cycles after issue until the result is readable from the register file.
- iss_hlt  in  1  instruction is HLT.
- cancel  in  1  squash the youngest issued write (taken branch).
- cancel_rd  in  RA_W  destination of the squashed write.
- stall  out  1  hold ID/IF this cycle.
- iss_fire  out  1  instruction accepted into EX.
- fwd_rs  out  1  rs value must come from the EX/MEM bypass.
- fwd_rt  out  1  rt value must come from the EX/MEM bypass.
- halted  out  1  HLT accepted; sticky until rst.
- drained  out  1  halted and all counters zero.
- stall_cnt  out  STAT_W  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, rst=1): all cnt[r]=0, halted=0, stall_cnt=0. Consequently stall=0, iss_fire=0, fwd_*=0 and drained=0.
- busy(r) = (r!=0) && cnt[r]!=0. Without forwarding, cnt[r] is the per-register threshold.
- Hazard = use_rs&&busy(rs) || use_rt&&busy(rt) || (iss_wr && rd!=0 && cnt[rd] > iss_lat). The last term is WAW: a younger write must not retire before an older one.
- stall = iss_valid && !halted && hazard.
- iss_fire = iss_valid && !halted && !hazard. Both outputs are combinational from registered state; issue-to-fire latency is 0 cycles.
- Each clock, every nonzero cnt decrements by 1.
- Same-cycle conflicts:
  - On fire with iss_wr && rd!=0 && iss_lat!=0: cnt[rd] <= iss_lat. This overrides the decrement.
  - cancel: cnt[cancel_rd] <= 0 and overrides both decrement and issue load to that register. A cancel and a fire in the same cycle are both honoured; the cancel wins on a shared register.
- A register whose counter reads 1 is still busy this cycle. The dependent fires on the next cycle with zero extra bubbles after expiry.
- rd==0 or iss_lat==0: nothing is tracked, and WAW is never raised.
- iss_lat > MAX_LAT is clamped to MAX_LAT.
- Fire with iss_hlt sets halted on the next edge.
- While halted: iss_fire=0, stall=0 and the stall statistic freezes; counters keep draining.
- drained = halted && all cnt==0.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-operation clears all in-flight tracking immediately, independent of clk.

Optional Feature:
- Macro: PIPE_SCOREBOARD_FORWARD_EN.
- Defined: a source register whose cnt==1 is not a hazard. fwd_rs/fwd_rt assert (combinationally, with iss_fire) for the matching used source, so a back-to-back ALU dependency issues with 0 bubbles.
  - The WAW rule is unchanged.
  - Load-use still stalls, because loads issue with iss_lat>=2.
- Undefined: fwd_rs/fwd_rt are tied to 0 and any cnt!=0 is a hazard.

Decomposition:
- Shared package pipe_pkg:
  - RA_W/LAT_W defaults.
  - MIPS opcode constants.
  - Latency constants LAT_ALU=1, LAT_LOAD=2.
  - The reg_idx_t typedef.
- One natural sub-module, pipe_sb_counter: a single-register down-counter with load, clear and priority. Instantiate it NREGS-1 times via generate.

Test Plan:
- Sequence: reset, then fire rd=1 with lat=2, then present rs=1. Expect stall=1 for 2 cycles, fire on the 3rd; stall_cnt=2.
- With FORWARD_EN: fire rd=4 with lat=1, then rs=4 next cycle. Expect iss_fire=1, fwd_rs=1, no stall. Without FORWARD_EN: 1 stall cycle.
- WAW: fire rd=3 with lat=4, next cycle fire rd=3 with lat=1. Expect stall until cnt[3]<=1, then fire, and cnt[3] reloads to 1.
- Cancel: fire rd=5 with lat=3, assert cancel rd=5 the next cycle. A dependent on rs=5 fires with no further stall. Cancel in the same cycle as a new write to 5 leaves cnt[5]=0.
- Halt: fire HLT with rd=2 still in flight (cnt=3). Expect halted=1 next edge and iss_fire held 0; drained rises exactly when cnt[2] reaches 0.
- Reset mid-stall: rst pulses while stall=1 and stall_cnt=7. Expect all outputs at reset values asynchronously, and a pending dependent fires on the first cycle after release.
